fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares a single synchronous FIFO's write port among NUM_REQ producers. Each producer presents a valid/ready/last stream; the arbiter locks one producer for a burst of up to MAX_BURST beats, then rotates. It sits directly in front of the FIFO: it drives the FIFO's write enable and write data and back-pressures on the FIFO's full flag. Read-side control is out of scope.

---
 rtl/fifo_wr_arbiter_if.sv | 45 ++++
 rtl/fifo_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter_if
//  Description : Producer-side valid/ready/last streams and FIFO write-port
//                signals of the round-robin FIFO write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   // Producer streams, one lane per requester
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;

   // FIFO write port
   logic                          fifo_w_en;
   logic [DATA_WIDTH-1:0]         fifo_wdata;
   logic                          fifo_full;

   // Arbiter side
   modport slave (
      input  req_valid,
      input  req_data,
      input  req_last,
      input  fifo_full,
      output req_ready,
      output fifo_w_en,
      output fifo_wdata
   );

   // Environment side (producers plus FIFO)
   modport master (
      output req_valid,
      output req_data,
      output req_last,
      output fifo_full,
      input  req_ready,
      input  fifo_w_en,
      input  fifo_wdata
   );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one synchronous FIFO write port
//                among NUM_REQ valid/ready/last producers. A granted producer
//                keeps the port for up to MAX_BURST beats or until its last
//                beat, then the grant rotates after one idle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   fifo_wr_arbiter_if.slave                if_arb,
   output logic [$clog2(NUM_REQ)-1:0]      o_grant_id,
   output logic                            o_busy
);

   localparam int c_ID_W  = $clog2(NUM_REQ);
   localparam int c_CNT_W = $clog2(MAX_BURST + 1);

   localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_BURST);
   localparam logic [c_ID_W-1:0]  c_LAST_RST = c_ID_W'(NUM_REQ - 1);

   localparam logic [0:0] c_ST_IDLE  = 1'b0;
   localparam logic [0:0] c_ST_BURST = 1'b1;

   // Registered state
   logic [0:0]         r_state;
   logic [c_ID_W-1:0]  r_grant_id;
   logic [c_ID_W-1:0]  r_last_grant;
   logic [c_CNT_W-1:0] r_beat_cnt;

   // Next-state values
   logic [0:0]         w_state_next;
   logic [c_ID_W-1:0]  w_grant_next;
   logic [c_ID_W-1:0]  w_last_grant_next;
   logic [c_CNT_W-1:0] w_cnt_next;

   // Arbitration and datapath helpers
   logic                  w_arb_hit;
   logic [c_ID_W-1:0]     w_arb_idx;
   logic [c_ID_W-1:0]     w_cand;
   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_in_burst;
   logic                  w_xfer;
   logic [c_CNT_W-1:0]    w_cnt_inc;
   logic                  w_burst_end;

   assign w_in_burst  = (r_state == c_ST_BURST);
   assign w_sel_valid = if_arb.req_valid[r_grant_id];
   assign w_sel_last  = if_arb.req_last[r_grant_id];
   assign w_xfer      = w_in_burst & w_sel_valid & ~if_arb.fifo_full;
   assign w_cnt_inc   = r_beat_cnt + c_CNT_W'(1);
   assign w_burst_end = w_sel_last | (w_cnt_inc == c_MAX_CNT);

   // Round-robin pick: scan last_grant+1, +2, ... modulo NUM_REQ. The scan
   // runs from the farthest candidate to the nearest so the nearest valid
   // requester is the final assignment and therefore wins.
   always_comb begin
      w_arb_hit = 1'b0;
      w_arb_idx = '0;
      w_cand    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = c_ID_W'((int'(r_last_grant) + k) % NUM_REQ);
         if (if_arb.req_valid[w_cand]) begin
            w_arb_hit = 1'b1;
            w_arb_idx = w_cand;
         end
      end
   end

   // Select the granted producer's data lane
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == c_ID_W'(i)) begin
            w_sel_data = if_arb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // State register: FSM state, grant, rotation pointer and beat counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_ST_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= c_LAST_RST;
         r_beat_cnt   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_grant_id   <= w_grant_next;
         r_last_grant <= w_last_grant_next;
         r_beat_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic: arbitrate in IDLE, count beats and close bursts in BURST
   always_comb begin
      w_state_next      = r_state;
      w_grant_next      = r_grant_id;
      w_last_grant_next = r_last_grant;
      w_cnt_next        = r_beat_cnt;
      case (r_state)
         c_ST_IDLE: begin
            if (w_arb_hit) begin
               w_state_next = c_ST_BURST;
               w_grant_next = w_arb_idx;
               w_cnt_next   = '0;
            end
         end
         c_ST_BURST: begin
            // A stalled or paused producer keeps its grant; only a real
            // transfer advances the burst.
            if (w_xfer) begin
               if (w_burst_end) begin
                  w_state_next      = c_ST_IDLE;
                  w_last_grant_next = r_grant_id;
                  w_cnt_next        = '0;
               end else begin
                  w_cnt_next = w_cnt_inc;
               end
            end
         end
         default: begin
            w_state_next = c_ST_IDLE;
         end
      endcase
   end

   // Output logic: ready only to the granted lane, write on handshake
   always_comb begin
      if_arb.req_ready  = '0;
      if_arb.fifo_w_en  = w_xfer;
      if_arb.fifo_wdata = w_sel_data;
      if (w_in_burst && !if_arb.fifo_full) begin
         if_arb.req_ready[r_grant_id] = 1'b1;
      end
   end

   assign o_grant_id = r_grant_id;
   assign o_busy     = w_in_burst;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Randomised scoreboard bench for fifo_wr_arbiter. A driver
//                issues producer traffic and FIFO-full patterns and pushes the
//                expected per-cycle response of a transaction-level model;
//                a monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int MB  = 4;
   localparam int IDW = $clog2(N);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

   logic [IDW-1:0] grant_id;
   logic           busy;

   fifo_wr_arbiter #(
      .NUM_REQ   (N),
      .DATA_WIDTH(DW),
      .MAX_BURST (MB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_arb    (bus.slave),
      .o_grant_id(grant_id),
      .o_busy    (busy)
   );

   typedef struct {
      bit            busy;
      int            gid;
      logic [N-1:0]  ready;
      bit            wen;
      logic [DW-1:0] wdata;
   } exp_t;

   exp_t q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_wr_model = 0;
   int n_wr_dut   = 0;

   // Transaction-level model: who owns the port (-1 = nobody), who owned it
   // last, how many beats the current owner has moved, what grant_id shows.
   int m_owner, m_last, m_cnt, m_gid;
   // Producers: beats left in current packet and running beat sequence
   int p_rem[N];
   int p_seq[N];

   function automatic logic [DW-1:0] beat_data(input int p, input int s);
      return DW'(p * 64 + (s % 64));
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = N - 1;
      m_cnt   = 0;
      m_gid   = 0;
   endtask

   task automatic chk(input string name, input longint act, input longint exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // One clock cycle of stimulus plus the model's expected response
   task automatic cycle(input bit rst_now, input int mask, input int lmin,
                        input int lmax, input int pv, input int pf);
      bit   v[N];
      bit   full;
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = ~rst_now;
      full  = ($urandom_range(99) < pf);
      bus.fifo_full = full;
      for (int i = 0; i < N; i++) begin
         if (p_rem[i] == 0 && ((mask >> i) & 1) == 1 && $urandom_range(99) < pv)
            p_rem[i] = $urandom_range(lmax, lmin);
         v[i] = (p_rem[i] > 0) && ($urandom_range(99) < pv);
         bus.req_valid[i] = v[i];
         bus.req_last[i]  = (p_rem[i] == 1);
         bus.req_data[i*DW +: DW] = beat_data(i, p_seq[i]);
      end
      if (rst_now) model_reset();

      e.busy  = (m_owner >= 0);
      e.gid   = m_gid;
      e.ready = (m_owner >= 0 && !full) ? N'(1 << m_owner) : '0;
      e.wen   = (m_owner >= 0) && v[m_owner] && !full;
      e.wdata = (m_owner >= 0) ? beat_data(m_owner, p_seq[m_owner]) : '0;
      q.push_back(e);

      if (!rst_now) begin
         if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
               if (m_owner < 0 && v[(m_last + k) % N]) begin
                  m_owner = (m_last + k) % N;
                  m_gid   = m_owner;
                  m_cnt   = 0;
               end
            end
         end else if (e.wen) begin
            bit was_last;
            was_last = (p_rem[m_owner] == 1);
            n_wr_model++;
            m_cnt++;
            p_seq[m_owner]++;
            p_rem[m_owner]--;
            if (was_last || m_cnt == MB) begin
               m_last  = m_owner;
               m_owner = -1;
               m_cnt   = 0;
            end
         end
      end
   endtask

   task automatic run(input int n, input int mask, input int lmin, input int lmax,
                      input int pv, input int pf);
      for (int c = 0; c < n; c++) cycle(1'b0, mask, lmin, lmax, pv, pf);
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (bus.fifo_w_en === 1'b1) n_wr_dut++;
            chk("busy",      longint'(busy),           longint'(e.busy));
            chk("grant_id",  longint'(grant_id),       longint'(e.gid));
            chk("req_ready", longint'(bus.req_ready),  longint'(e.ready));
            chk("fifo_w_en", longint'(bus.fifo_w_en),  longint'(e.wen));
            if (e.wen) chk("fifo_wdata", longint'(bus.fifo_wdata), longint'(e.wdata));
         end
      end
   end

   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < N; i++) begin
         p_rem[i] = 0;
         p_seq[i] = 0;
      end
      model_reset();

      // Reset held with every producer requesting
      for (int c = 0; c < 4; c++) cycle(1'b1, 4'hF, 2, 2, 100, 0);
      // Round-robin, 2-beat packets, FIFO never full
      run(40, 4'hF, 2, 2, 100, 0);
      run(30, 0, 1, 1, 100, 0);
      // Burst cap: producer 2 alone with a 10-beat packet
      run(13, 4'b0100, 10, 10, 100, 0);
      run(30, 0, 1, 1, 100, 0);
      // Back-pressure on producer 1
      run(60, 4'b0010, 6, 8, 100, 35);
      run(30, 0, 1, 1, 100, 0);
      // Lock hold: producers 0 and 3 with gappy valids
      run(80, 4'b1001, 3, 8, 40, 0);
      run(40, 0, 1, 1, 100, 0);
      // Reset during beat 2 of a 4-beat burst from producer 0
      run(2, 4'b0001, 4, 4, 100, 0);
      cycle(1'b1, 4'b0001, 4, 4, 100, 0);
      cycle(1'b1, 4'b0001, 4, 4, 100, 0);
      run(20, 0, 1, 1, 100, 0);
      // Random traffic with occasional resets
      for (int c = 0; c < 2000; c++)
         cycle(($urandom_range(299) == 0), 4'hF, 1, 10, 70, 25);
      run(80, 0, 1, 1, 100, 0);

      @(negedge clk);
      #1;
      chk("queue_drained", longint'(q.size()), 0);
      chk("write_count", longint'(n_wr_dut), longint'(n_wr_model));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
